// File: rtl/connectfour_pkg.sv
// Shared types and constants for the connect-four board and win checkers.
// Board geometry, slice typedefs, drop FSM states and player encodings.
package connectfour_pkg;

    localparam int COLS_C = 7;
    localparam int ROWS_C = 6;

    typedef logic [COLS_C-1:0] row_t;
    typedef logic [ROWS_C-1:0] col_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_PRESENT,
        ST_REJECT
    } drop_state_t;

    localparam logic PLAYER0 = 1'b0;
    localparam logic PLAYER1 = 1'b1;

endpackage

// File: rtl/connectfour_board_regs.sv
// Board storage: occupied and owner bit-planes, one write port,
// a row-slice and a column-slice read port, plus a single-cell probe.
module connectfour_board_regs
    import connectfour_pkg::*;
#(
    parameter int COLS = COLS_C,
    parameter int ROWS = ROWS_C
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            we,
    input  logic [2:0]      wr_row,
    input  logic [2:0]      wr_col,
    input  logic            wr_player,
    input  logic [2:0]      rd_row,
    input  logic [2:0]      rd_col,
    input  logic [2:0]      probe_row,
    input  logic [2:0]      probe_col,
    output logic            probe_occ,
    output logic [COLS-1:0] row_player,
    output logic [COLS-1:0] row_onoff,
    output logic [ROWS-1:0] col_player,
    output logic [ROWS-1:0] col_onoff,
    output logic            top_full
);

    logic [COLS-1:0] occ [ROWS];
    logic [COLS-1:0] own [ROWS];

    // Clear both planes, or place one piece; owner stays 0 on empty cells.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int j = 0; j < ROWS; j++) begin
                occ[j] <= '0;
                own[j] <= {COLS{PLAYER0}};
            end
        end else if (we) begin
            occ[wr_row][wr_col] <= 1'b1;
            own[wr_row][wr_col] <= wr_player;
        end
    end

    assign row_onoff  = occ[rd_row];
    assign row_player = own[rd_row];
    assign probe_occ  = occ[probe_row][probe_col];
    assign top_full   = &occ[ROWS-1];

    // Gather one column across all rows into a vertical slice.
    always_comb begin
        col_onoff  = '0;
        col_player = '0;
        for (int j = 0; j < ROWS; j++) begin
            col_onoff[j]  = occ[j][rd_col];
            col_player[j] = own[j][rd_col];
        end
    end

endmodule

// File: rtl/connectfour_board_drop.sv
// Drop FSM: scans a column bottom-up for the first free cell, writes
// the piece, then presents the row/column slices for the win checkers.
module connectfour_board_drop
    import connectfour_pkg::*;
#(
    parameter int COLS = COLS_C,
    parameter int ROWS = ROWS_C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            new_game,
    input  logic            drop_req,
    input  logic [2:0]      drop_col,
    input  logic            player,
    output logic            ready,
    output logic            drop_ack,
    output logic            drop_invalid,
    output logic [2:0]      placed_row,
    output logic [2:0]      placed_col,
    output logic [COLS-1:0] row_player,
    output logic [COLS-1:0] row_onoff,
    output logic [ROWS-1:0] col_player,
    output logic [ROWS-1:0] col_onoff,
    output logic            check_valid,
    output logic            board_full
);

    drop_state_t state, state_n;
    logic [2:0]  col_q, col_n;
    logic [2:0]  row_q, row_n;
    logic        player_q, player_n;
    logic        clear;
    logic        probe_occ;

    assign clear = reset | new_game;

    connectfour_board_regs #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_regs (
        .clk        (clk),
        .clear      (clear),
        .we         (state == ST_WRITE),
        .wr_row     (row_q),
        .wr_col     (col_q),
        .wr_player  (player_q),
        .rd_row     (placed_row),
        .rd_col     (placed_col),
        .probe_row  (row_q),
        .probe_col  (col_q),
        .probe_occ  (probe_occ),
        .row_player (row_player),
        .row_onoff  (row_onoff),
        .col_player (col_player),
        .col_onoff  (col_onoff),
        .top_full   (board_full)
    );

    // State, latched request and scan pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            player_q <= 1'b0;
        end else begin
            state    <= state_n;
            col_q    <= col_n;
            row_q    <= row_n;
            player_q <= player_n;
        end
    end

    // Last placement; slices read the board at this cell.
    always_ff @(posedge clk) begin
        if (clear) begin
            placed_row <= '0;
            placed_col <= '0;
        end else if (state == ST_WRITE) begin
            placed_row <= row_q;
            placed_col <= col_q;
        end
    end

    // Next-state logic; a board clear overrides any state or request.
    always_comb begin
        state_n  = state;
        col_n    = col_q;
        row_n    = row_q;
        player_n = player_q;
        if (clear) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (drop_req) begin
                        col_n    = drop_col;
                        player_n = player;
                        row_n    = '0;
                        if (int'(drop_col) >= COLS) state_n = ST_REJECT;
                        else                        state_n = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!probe_occ)                   state_n = ST_WRITE;
                    else if (row_q == 3'(ROWS - 1))   state_n = ST_REJECT;
                    else                              row_n   = row_q + 3'd1;
                end
                ST_WRITE:   state_n = ST_PRESENT;
                ST_PRESENT: state_n = ST_IDLE;
                ST_REJECT:  state_n = ST_IDLE;
                default:    state_n = ST_IDLE;
            endcase
        end
    end

    assign ready        = (state == ST_IDLE);
    assign drop_ack     = (state == ST_PRESENT);
    assign check_valid  = (state == ST_PRESENT);
    assign drop_invalid = (state == ST_REJECT);

endmodule

// File: tb/tb_connectfour_board_drop.sv
// Bench for connectfour_board_drop: directed test-plan cases with literal
// expectations, then random traffic checked every cycle against a model.
module tb_connectfour_board_drop;

    localparam int C = 7;
    localparam int R = 6;

    logic         clk;
    logic         reset;
    logic         new_game;
    logic         drop_req;
    logic [2:0]   drop_col;
    logic         player;
    logic         ready;
    logic         drop_ack;
    logic         drop_invalid;
    logic [2:0]   placed_row;
    logic [2:0]   placed_col;
    logic [C-1:0] row_player;
    logic [C-1:0] row_onoff;
    logic [R-1:0] col_player;
    logic [R-1:0] col_onoff;
    logic         check_valid;
    logic         board_full;

    connectfour_board_drop dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .drop_req     (drop_req),
        .drop_col     (drop_col),
        .player       (player),
        .ready        (ready),
        .drop_ack     (drop_ack),
        .drop_invalid (drop_invalid),
        .placed_row   (placed_row),
        .placed_col   (placed_col),
        .row_player   (row_player),
        .row_onoff    (row_onoff),
        .col_player   (col_player),
        .col_onoff    (col_onoff),
        .check_valid  (check_valid),
        .board_full   (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: board as a column-major grid of cells; each accepted
    // request becomes one scheduled outcome, timed by the column's height.
    bit mocc [C][R];
    bit mown [C][R];
    int m_prow, m_pcol;
    bit pend;
    int off, when_c;
    bit okv;
    int tcol, trow, h;
    bit tply;
    bit e_ack, e_inv;

    function automatic int height(input int c);
        int n = 0;
        for (int j = 0; j < R; j++) if (mocc[c][j]) n++;
        return n;
    endfunction

    task fire();
        if (off == when_c) begin
            if (okv) begin
                mocc[tcol][trow] = 1'b1;
                mown[tcol][trow] = tply;
                m_prow = trow;
                m_pcol = tcol;
                e_ack = 1'b1;
            end else begin
                e_inv = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        e_ack = 1'b0;
        e_inv = 1'b0;
        if (reset || new_game) begin
            for (int c = 0; c < C; c++)
                for (int j = 0; j < R; j++) begin
                    mocc[c][j] = 1'b0;
                    mown[c][j] = 1'b0;
                end
            m_prow = 0;
            m_pcol = 0;
            pend = 1'b0;
        end else if (pend && off == when_c) begin
            pend = 1'b0;
        end else if (pend) begin
            off++;
            fire();
        end else if (drop_req) begin
            tcol = int'(drop_col);
            tply = player;
            pend = 1'b1;
            off = 1;
            if (tcol >= C) begin
                okv = 1'b0;
                when_c = 1;
            end else begin
                h = height(tcol);
                if (h >= R) begin
                    okv = 1'b0;
                    when_c = R + 1;
                end else begin
                    okv = 1'b1;
                    trow = h;
                    when_c = h + 3;
                end
            end
            fire();
        end
    end

    // Every cycle after the first reset, all outputs must match the model.
    always @(negedge clk) begin
        logic [C-1:0] er, erp;
        logic [R-1:0] ec, ecp;
        bit full;
        if (chk_en) begin
            er = '0; erp = '0; ec = '0; ecp = '0;
            full = 1'b1;
            for (int c = 0; c < C; c++) begin
                er[c]  = mocc[c][m_prow];
                erp[c] = mown[c][m_prow];
                full   = full & mocc[c][R-1];
            end
            for (int j = 0; j < R; j++) begin
                ec[j]  = mocc[m_pcol][j];
                ecp[j] = mown[m_pcol][j];
            end
            chk("ready",       32'(ready),        32'(!pend));
            chk("drop_ack",    32'(drop_ack),     32'(e_ack));
            chk("check_valid", 32'(check_valid),  32'(e_ack));
            chk("drop_inv",    32'(drop_invalid), 32'(e_inv));
            chk("placed_row",  32'(placed_row),   32'(m_prow));
            chk("placed_col",  32'(placed_col),   32'(m_pcol));
            chk("row_onoff",   32'(row_onoff),    32'(er));
            chk("row_player",  32'(row_player),   32'(erp));
            chk("col_onoff",   32'(col_onoff),    32'(ec));
            chk("col_player",  32'(col_player),   32'(ecp));
            chk("board_full",  32'(board_full),   32'(full));
        end
    end

    task automatic do_drop(input int c, input bit p, output int lat,
                           output bit acked, output bit inv);
        @(posedge clk);
        #2 drop_req = 1'b1;
        drop_col = 3'(c);
        player = p;
        @(posedge clk);
        #2 drop_req = 1'b0;
        lat = 0;
        acked = 1'b0;
        inv = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (drop_ack || drop_invalid) begin
                lat = i;
                acked = drop_ack;
                inv = drop_invalid;
                break;
            end
        end
        chk("drop_done", 32'(acked | inv), 32'd1);
    endtask

    task automatic pulse_new_game();
        @(posedge clk);
        #2 new_game = 1'b1;
        @(posedge clk);
        #2 new_game = 1'b0;
    endtask

    int lat;
    bit acked, inv;
    int extra;

    initial begin
        reset = 1'b1;
        new_game = 1'b0;
        drop_req = 1'b0;
        drop_col = '0;
        player = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_ready",     32'(ready),      32'd1);
        chk("rst_row_onoff", 32'(row_onoff),  32'd0);
        chk("rst_placed",    32'(placed_row), 32'd0);

        do_drop(3, 1'b1, lat, acked, inv);
        chk("d1_lat",        32'(lat),        32'd3);
        chk("d1_ack",        32'(acked),      32'd1);
        chk("d1_placed_row", 32'(placed_row), 32'd0);
        chk("d1_placed_col", 32'(placed_col), 32'd3);
        chk("d1_row_onoff",  32'(row_onoff),  32'(7'b0001000));
        chk("d1_row_player", 32'(row_player), 32'(7'b0001000));
        chk("d1_col_onoff",  32'(col_onoff),  32'(6'b000001));

        for (int k = 1; k <= 3; k++) begin
            do_drop(3, 1'(k % 2 == 0), lat, acked, inv);
            chk("d3_placed_row", 32'(placed_row), 32'(k));
        end
        chk("d4_lat",        32'(lat),        32'd6);
        chk("d4_col_onoff",  32'(col_onoff),  32'(6'b001111));
        chk("d4_col_player", 32'(col_player), 32'(6'b000101));

        for (int k = 0; k < R; k++) do_drop(0, 1'(k % 2), lat, acked, inv);
        do_drop(0, 1'b1, lat, acked, inv);
        chk("full_lat",      32'(lat),        32'd7);
        chk("full_no_ack",   32'(acked),      32'd0);
        chk("full_placed",   32'(placed_row), 32'd5);
        chk("full_col",      32'(col_onoff),  32'(6'b111111));

        do_drop(7, 1'b0, lat, acked, inv);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_inv", 32'(inv), 32'd1);
        @(negedge clk);
        chk("oor_ready", 32'(ready), 32'd1);

        @(posedge clk);
        #2 drop_req = 1'b1;
        drop_col = 3'd0;
        player = 1'b1;
        @(posedge clk);
        #2 new_game = 1'b1;
        drop_col = 3'd4;
        @(posedge clk);
        #2 new_game = 1'b0;
        drop_req = 1'b0;
        @(negedge clk);
        chk("ng_ready",     32'(ready),      32'd1);
        chk("ng_col_onoff", 32'(col_onoff),  32'd0);
        chk("ng_row_onoff", 32'(row_onoff),  32'd0);
        chk("ng_placed",    32'(placed_col), 32'd0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (drop_ack || drop_invalid) extra++;
        end
        chk("ng_no_ack", 32'(extra), 32'd0);

        pulse_new_game();
        for (int k = 0; k < C * R; k++) begin
            do_drop(k % C, 1'(k % 2), lat, acked, inv);
            chk("fill_lat", 32'(lat), 32'(k / C + 3));
            chk("fill_full", 32'(board_full), 32'(k == C * R - 1));
        end
        do_drop(2, 1'b0, lat, acked, inv);
        chk("bf_rej_lat", 32'(lat),        32'd7);
        chk("bf_hold",    32'(board_full), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2 drop_req = 1'($urandom_range(0, 1));
            drop_col = 3'($urandom_range(0, 7));
            player = 1'($urandom_range(0, 1));
            new_game = ($urandom_range(0, 119) == 0);
            reset = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #2 drop_req = 1'b0;
        new_game = 1'b0;
        reset = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
